gamepad_pmod_rx: RTL and testbench



---
 rtl/gamepad_pmod_rx_pkg.sv | 41 ++++
 rtl/gamepad_pmod_rx_if.sv | 31 +++
 rtl/gamepad_pmod_rx_sync_rise.sv | 33 +++
 rtl/gamepad_pmod_rx.sv | 89 ++++++++
 tb/tb_gamepad_pmod_rx.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gamepad_pmod_rx_pkg.sv
// Purpose: shared constants, pad word type and presence decode for the gamepad PMOD receiver.
// Latency: none. This file holds only types, constants and a combinational helper.
// Backpressure: none.
package gamepad_pkg;

  localparam int FRAME_BITS = 24;
  localparam int PAD_BITS   = 12;

  // Button positions inside a 12-bit pad word, MSB first.
  localparam int BTN_B      = 11;
  localparam int BTN_Y      = 10;
  localparam int BTN_SELECT = 9;
  localparam int BTN_START  = 8;
  localparam int BTN_UP     = 7;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_A      = 3;
  localparam int BTN_X      = 2;
  localparam int BTN_L      = 1;
  localparam int BTN_R      = 0;

  typedef logic [PAD_BITS-1:0] pad_t;

  // A disconnected controller reads back as all buttons pressed.
  localparam pad_t PAD_ABSENT = 12'hFFF;

  typedef struct packed {
    pad_t pad;
    logic present;
  } pad_state_t;

  // An absent controller shows no buttons pressed and clears its present flag.
  function automatic pad_state_t decode_pad(pad_t word);
    pad_state_t s;
    s.present = (word != PAD_ABSENT);
    s.pad     = s.present ? word : '0;
    return s;
  endfunction

endpackage

// File: rtl/gamepad_pmod_rx_if.sv
// Purpose: bundles the PMOD pin inputs and the decoded pad outputs of the receiver.
// Latency: none. This is wiring only.
// Backpressure: none. Pins are free-running and the outputs are level/pulse signals.
interface gamepad_pmod_rx_if;
  import gamepad_pkg::*;

  logic io_pmod_latch;
  logic io_pmod_clk;
  logic io_pmod_data;
  pad_t io_pad1;
  pad_t io_pad2;
  logic io_pad1_present;
  logic io_pad2_present;
  logic io_frame_valid;
  logic io_frame_error;

  // The master side drives the PMOD pins and observes the decoded pads.
  modport master (
    output io_pmod_latch, io_pmod_clk, io_pmod_data,
    input  io_pad1, io_pad2, io_pad1_present, io_pad2_present,
    input  io_frame_valid, io_frame_error
  );

  // The slave side is the receiver itself.
  modport slave (
    input  io_pmod_latch, io_pmod_clk, io_pmod_data,
    output io_pad1, io_pad2, io_pad1_present, io_pad2_present,
    output io_frame_valid, io_frame_error
  );

endinterface

// File: rtl/gamepad_pmod_rx_sync_rise.sv
// Purpose: N-stage synchroniser for one asynchronous pin, followed by a registered rising-edge detect.
// Latency: the level and rise outputs appear STAGES+1 cycles after the pin is sampled.
// Backpressure: none. The input is free-running.
module sync_rise #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Shift the pin through the synchroniser. The last stage is registered once more,
  // so that the level and the rise pulse line up on the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= (sync << 1) | STAGES'(din);
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
    end
  end

  assign level = prev;

endmodule

// File: rtl/gamepad_pmod_rx.sv
// Purpose: deserialises 24-bit Gamepad PMOD frames into registered button state for two controllers.
// Latency: outputs update 4 cycles after the latch pin rises (SYNC_STAGES=2). Valid/error pulses last 1 cycle.
// Backpressure: none. Frames are committed or discarded as they arrive.
module gamepad_pmod_rx
  import gamepad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = gamepad_pkg::FRAME_BITS
) (
  input  logic clock,
  input  logic reset,
  gamepad_pmod_rx_if.slave bus
);

  localparam int             CNT_W     = 5;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

  logic latch_rise, clk_rise, data_lvl;
  logic latch_lvl_unused, clk_lvl_unused, data_rise_unused;

  logic [FRAME_BITS-1:0] sr;
  logic [CNT_W-1:0]      cnt;
  pad_t                  pad1_q, pad2_q;
  logic                  pad1_present_q, pad2_present_q;
  logic                  valid_q, error_q;
  pad_state_t            pad1_dec, pad2_dec;

  sync_rise #(.STAGES(SYNC_STAGES)) u_latch (
    .clock(clock), .reset(reset), .din(bus.io_pmod_latch),
    .level(latch_lvl_unused), .rise(latch_rise)
  );

  sync_rise #(.STAGES(SYNC_STAGES)) u_clk (
    .clock(clock), .reset(reset), .din(bus.io_pmod_clk),
    .level(clk_lvl_unused), .rise(clk_rise)
  );

  // Data goes through the same pipeline, so it is aligned with the clk edge detect.
  sync_rise #(.STAGES(SYNC_STAGES)) u_data (
    .clock(clock), .reset(reset), .din(bus.io_pmod_data),
    .level(data_lvl), .rise(data_rise_unused)
  );

  // The first bit shifted in ends up in the MSB, so pad2 occupies the upper half.
  assign pad2_dec = decode_pad(sr[2*PAD_BITS-1:PAD_BITS]);
  assign pad1_dec = decode_pad(sr[PAD_BITS-1:0]);

  // Shift on clk edges. On a latch edge, commit or discard the frame. A latch edge
  // wins over a clk edge in the same cycle, so that the frame is judged on the count it has.
  always_ff @(posedge clock) begin
    if (reset) begin
      sr             <= '0;
      cnt            <= '0;
      pad1_q         <= '0;
      pad2_q         <= '0;
      pad1_present_q <= 1'b0;
      pad2_present_q <= 1'b0;
      valid_q        <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (latch_rise) begin
        cnt <= '0;
        if (cnt == FRAME_CNT) begin
          pad1_q         <= pad1_dec.pad;
          pad2_q         <= pad2_dec.pad;
          pad1_present_q <= pad1_dec.present;
          pad2_present_q <= pad2_dec.present;
          valid_q        <= 1'b1;
        end else begin
          error_q <= 1'b1;
        end
      end else if (clk_rise) begin
        sr <= {sr[FRAME_BITS-2:0], data_lvl};
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.io_pad1         = pad1_q;
  assign bus.io_pad2         = pad2_q;
  assign bus.io_pad1_present = pad1_present_q;
  assign bus.io_pad2_present = pad2_present_q;
  assign bus.io_frame_valid  = valid_q;
  assign bus.io_frame_error  = error_q;

endmodule

// File: tb/tb_gamepad_pmod_rx.sv
// Purpose: drives PMOD pin waveforms into gamepad_pmod_rx and checks it against a frame-level model.
// Latency: the model expects the effects of each latch 4 cycles after the latch pin rises.
// Backpressure: none.
module tb_gamepad_pmod_rx;
  import gamepad_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  gamepad_pmod_rx_if bus();

  gamepad_pmod_rx #(.SYNC_STAGES(2), .FRAME_BITS(24)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int         apply;
    bit         good;
    logic [11:0] pad1;
    logic [11:0] pad2;
  } ev_t;

  ev_t  evq[$];
  bit   bits_q[$];
  int   rst_cyc = 1;
  bit   done    = 1'b0;
  bit   fast    = 1'b1;

  logic [11:0] m_pad1 = '0, m_pad2 = '0;
  bit          m_p1 = 1'b0, m_p2 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic int ph();
    return fast ? 2 : int'($urandom_range(2, 4));
  endfunction

  // Record what a latch rising now must do, judged on the bits seen since the last latch.
  task automatic make_event();
    ev_t e;
    logic [23:0] w;
    w = '0;
    foreach (bits_q[i]) w = {w[22:0], bits_q[i]};
    e.apply = cyc + 4;
    e.good  = (bits_q.size() == 24);
    e.pad2  = w[23:12];
    e.pad1  = w[11:0];
    evq.push_back(e);
    bits_q.delete();
  endtask

  task automatic send_bit(input bit b);
    bus.io_pmod_clk  = 1'b0;
    bus.io_pmod_data = b;
    step(ph());
    bus.io_pmod_clk = 1'b1;
    bits_q.push_back(b);
    step(ph());
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom));
  endtask

  // Latch high and low phases are both 2 cycles, so the effect is visible on return.
  task automatic do_latch();
    bus.io_pmod_clk = 1'b0;
    step(ph());
    bus.io_pmod_latch = 1'b1;
    make_event();
    step(2);
    bus.io_pmod_latch = 1'b0;
    step(2);
  endtask

  // clk and latch rise together; the clk edge must not count.
  task automatic do_coincident();
    bus.io_pmod_clk  = 1'b0;
    bus.io_pmod_data = 1'($urandom);
    step(ph());
    bus.io_pmod_clk   = 1'b1;
    bus.io_pmod_latch = 1'b1;
    make_event();
    step(2);
    bus.io_pmod_clk   = 1'b0;
    bus.io_pmod_latch = 1'b0;
    step(2);
  endtask

  task automatic do_reset(input int n);
    reset             = 1'b1;
    bus.io_pmod_latch = 1'b0;
    bus.io_pmod_clk   = 1'b0;
    bus.io_pmod_data  = 1'b0;
    rst_cyc           = cyc + 1;
    bits_q.delete();
    step(n);
    reset = 1'b0;
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clock) begin
    bit  exp_v, exp_e;
    ev_t e;
    if (cyc >= 1 && !done) begin
      exp_v = 1'b0;
      exp_e = 1'b0;
      if (cyc == rst_cyc) begin
        evq.delete();
        m_pad1 = '0; m_pad2 = '0; m_p1 = 1'b0; m_p2 = 1'b0;
      end else if (evq.size() > 0 && evq[0].apply == cyc) begin
        e = evq.pop_front();
        if (e.good) begin
          exp_v  = 1'b1;
          m_p1   = (e.pad1 != 12'hFFF);
          m_p2   = (e.pad2 != 12'hFFF);
          m_pad1 = m_p1 ? e.pad1 : 12'h000;
          m_pad2 = m_p2 ? e.pad2 : 12'h000;
        end else begin
          exp_e = 1'b1;
        end
      end
      check("pad1",     32'(bus.io_pad1),         32'(m_pad1));
      check("pad2",     32'(bus.io_pad2),         32'(m_pad2));
      check("present1", 32'(bus.io_pad1_present), 32'(m_p1));
      check("present2", 32'(bus.io_pad2_present), 32'(m_p2));
      check("valid",    32'(bus.io_frame_valid),  32'(exp_v));
      check("error",    32'(bus.io_frame_error),  32'(exp_e));
    end
  end

  initial begin
    logic [11:0] p1, p2;
    int len;
    bus.io_pmod_latch = 1'b0;
    bus.io_pmod_clk   = 1'b0;
    bus.io_pmod_data  = 1'b0;
    step(4);
    reset = 1'b0;
    step(2);

    check("lit_rst_pad1",   32'(bus.io_pad1), 32'h000);
    check("lit_rst_pad2",   32'(bus.io_pad2), 32'h000);
    check("lit_rst_pres",   32'({bus.io_pad1_present, bus.io_pad2_present}), 32'h0);
    check("lit_rst_pulses", 32'({bus.io_frame_valid, bus.io_frame_error}), 32'h0);

    // pad1 with A held, pad2 idle
    send_word({12'h000, 12'h008});
    do_latch();
    check("lit_a_valid", 32'(bus.io_frame_valid), 32'h1);
    check("lit_a_pad1",  32'(bus.io_pad1), 32'h008);
    check("lit_a_pad2",  32'(bus.io_pad2), 32'h000);
    check("lit_a_pres",  32'({bus.io_pad1_present, bus.io_pad2_present}), 32'h3);
    step(1);
    check("lit_a_valid_end", 32'(bus.io_frame_valid), 32'h0);

    // pad2 absent, pad1 with B held
    send_word({12'hFFF, 12'h800});
    do_latch();
    check("lit_abs_pad2", 32'(bus.io_pad2), 32'h000);
    check("lit_abs_pres", 32'({bus.io_pad1_present, bus.io_pad2_present}), 32'h2);
    check("lit_abs_pad1", 32'(bus.io_pad1), 32'h800);

    fast = 1'b0;
    send_rand(23);
    do_latch();
    check("lit_short_err",  32'(bus.io_frame_error), 32'h1);
    check("lit_short_pad1", 32'(bus.io_pad1), 32'h800);

    send_rand(40);
    do_latch();
    check("lit_long_err", 32'(bus.io_frame_error), 32'h1);

    send_rand(23);
    do_coincident();
    check("lit_coinc_err",  32'(bus.io_frame_error), 32'h1);
    check("lit_coinc_pad1", 32'(bus.io_pad1), 32'h800);
    send_word({12'h123, 12'h456});
    do_latch();
    check("lit_after_coinc", 32'({bus.io_frame_valid, bus.io_pad2, bus.io_pad1}), {7'd0, 1'b1, 24'h123456});

    // back-to-back at minimum phase width
    fast = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_word({12'h000, (i % 2 == 0) ? 12'h0F0 : 12'h00F});
      do_latch();
      check("lit_b2b", 32'({bus.io_frame_valid, bus.io_pad1}), {19'd0, 1'b1, (i % 2 == 0) ? 12'h0F0 : 12'h00F});
    end

    // reset in the middle of a frame
    fast = 1'b0;
    send_word({12'h0A5, 12'h5A0});
    do_latch();
    send_rand(12);
    do_reset(2);
    step(2);
    check("lit_midrst_pads", 32'({bus.io_pad2, bus.io_pad1}), 32'h0);
    send_rand(10);
    do_latch();
    check("lit_midrst_err",  32'(bus.io_frame_error), 32'h1);
    check("lit_midrst_pads2", 32'({bus.io_pad2, bus.io_pad1, bus.io_pad1_present, bus.io_pad2_present}), 32'h0);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      fast = ($urandom_range(0, 3) == 0);
      p1 = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
      p2 = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 30)) : 24;
      if (len == 24) send_word({p2, p1});
      else send_rand(len);
      if ($urandom_range(0, 9) == 0) do_coincident();
      else do_latch();
      step(int'($urandom_range(0, 3)));
    end

    step(10);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
